ht_host_port: RTL

//  Host-side counterpart of hash_table_top, and synthesizable replacement for the bench's always-ready sink.

---
 rtl/ht_host_port_if.sv | 39 +++
 rtl/ht_host_port.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ht_host_port_if.sv
// ht_host_port_if.sv
// Stream interfaces used around ht_host_port.
//   ht_cmd_if : command stream (opcode, key, value)
//   ht_res_if : result stream  (opcode, key, rescode, value)
// Handshake rule for both streams: a beat transfers on a rising clk edge
// where valid and ready are both high. Once valid is raised, the master
// holds valid and every field stable until that transfer. Ready may change
// freely and must not be required before valid is raised.
// Modports: master drives valid + fields and reads ready; slave is the mirror.

interface ht_cmd_if #(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16
);
  logic                   valid;
  logic                   ready;
  logic [1:0]             opcode;
  logic [KEY_WIDTH-1:0]   key;
  logic [VALUE_WIDTH-1:0] value;

  modport master (output valid, opcode, key, value, input ready);
  modport slave  (input valid, opcode, key, value, output ready);
endinterface

interface ht_res_if #(
  parameter int KEY_WIDTH     = 32,
  parameter int VALUE_WIDTH   = 16,
  parameter int RESCODE_WIDTH = 3
);
  logic                     valid;
  logic                     ready;
  logic [1:0]               opcode;
  logic [KEY_WIDTH-1:0]     key;
  logic [RESCODE_WIDTH-1:0] rescode;
  logic [VALUE_WIDTH-1:0]   value;

  modport master (output valid, opcode, key, rescode, value, input ready);
  modport slave  (input valid, opcode, key, rescode, value, output ready);
endinterface

// File: rtl/ht_host_port.sv
// ht_host_port.sv
// Host-side port for hash_table_top. Registers host commands onto the
// ht_cmd stream, limits the number of commands whose result has not yet
// come back, buffers results in a small FIFO for the host and flags a
// result that arrives with no command outstanding.
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   host_cmd        (slave)  commands from the host
//   ht_cmd          (master) commands towards hash_table_top
//   ht_res          (slave)  results from hash_table_top
//   host_res        (master) buffered results towards the host
//   outstanding_o   commands accepted whose result has not been taken
//   err_underflow_o sticky, result taken while outstanding_o was 0
// Optional (macro HT_HOST_PORT_STATS_EN):
//   stat_clr_i      synchronous clear of the statistics counters
//   stat_search_o / stat_insert_o / stat_delete_o
//                   saturating counts of results taken per opcode
//
// KEY_WIDTH / VALUE_WIDTH and the opcode encoding must match hash_table.

module ht_host_port #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int RES_FIFO_DEPTH  = 4,
  parameter int RESCODE_WIDTH   = 3,
  parameter int KEY_WIDTH       = 32,
  parameter int VALUE_WIDTH     = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ht_cmd_if.slave    host_cmd,
  ht_cmd_if.master   ht_cmd,
  ht_res_if.slave    ht_res,
  ht_res_if.master   host_res,
  output logic [7:0] outstanding_o,
  output logic       err_underflow_o
`ifdef HT_HOST_PORT_STATS_EN
  ,
  input  logic        stat_clr_i,
  output logic [31:0] stat_search_o,
  output logic [31:0] stat_insert_o,
  output logic [31:0] stat_delete_o
`endif
);

  localparam logic [1:0] OP_SEARCH = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;

  localparam int AW = $clog2(RES_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 + KEY_WIDTH + RESCODE_WIDTH + VALUE_WIDTH;
  localparam logic [7:0]    MAX_OS  = 8'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_C = CW'(RES_FIFO_DEPTH);

  // ---------------- command path ----------------
  logic                   cmd_valid_q;
  logic [1:0]             cmd_opcode_q;
  logic [KEY_WIDTH-1:0]   cmd_key_q;
  logic [VALUE_WIDTH-1:0] cmd_value_q;
  logic                   credit_ok_q;
  logic                   host_cmd_fire;
  logic                   ht_cmd_fire;

  // Credit is a registered flag so host_cmd.ready has no path from ht_res.
  assign host_cmd.ready = (!cmd_valid_q || ht_cmd.ready) && credit_ok_q;
  assign host_cmd_fire  = host_cmd.valid && host_cmd.ready;
  assign ht_cmd_fire    = cmd_valid_q && ht_cmd.ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= '0;
      cmd_key_q    <= '0;
      cmd_value_q  <= '0;
    end else if (host_cmd_fire) begin
      cmd_valid_q  <= 1'b1;
      cmd_opcode_q <= host_cmd.opcode;
      cmd_key_q    <= host_cmd.key;
      cmd_value_q  <= host_cmd.value;
    end else if (ht_cmd_fire) begin
      cmd_valid_q  <= 1'b0;
    end
  end

  assign ht_cmd.valid  = cmd_valid_q;
  assign ht_cmd.opcode = cmd_opcode_q;
  assign ht_cmd.key    = cmd_key_q;
  assign ht_cmd.value  = cmd_value_q;

  // ---------------- credit ----------------
  logic [7:0] out_q;
  logic [7:0] out_next;
  logic       err_q;
  logic       res_fire;

  always_comb begin
    out_next = out_q;
    if (host_cmd_fire && !res_fire) begin
      out_next = out_q + 8'd1;
    end else if (!host_cmd_fire && res_fire && (out_q != 8'd0)) begin
      out_next = out_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= '0;
      credit_ok_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_q       <= out_next;
      credit_ok_q <= (out_next < MAX_OS);
      if (res_fire && (out_q == 8'd0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign outstanding_o   = out_q;
  assign err_underflow_o = err_q;

  // ---------------- result FIFO ----------------
  logic [EW-1:0] mem [RES_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_next;
  logic          res_ready_q;
  logic          host_res_fire;

  assign res_fire      = ht_res.valid && res_ready_q;
  assign host_res_fire = host_res.valid && host_res.ready;

  always_comb begin
    cnt_next = cnt_q;
    case ({res_fire, host_res_fire})
      2'b10:   cnt_next = cnt_q + 1'b1;
      2'b01:   cnt_next = cnt_q - 1'b1;
      default: cnt_next = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_q       <= '0;
      res_ready_q <= 1'b0;
      for (int i = 0; i < RES_FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (res_fire) begin
        mem[wr_ptr] <= {ht_res.opcode, ht_res.key, ht_res.rescode, ht_res.value};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (host_res_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt_q       <= cnt_next;
      res_ready_q <= (cnt_next < DEPTH_C);
    end
  end

  assign ht_res.ready   = res_ready_q;
  assign host_res.valid = (cnt_q != '0);
  assign {host_res.opcode, host_res.key, host_res.rescode, host_res.value} = mem[rd_ptr];

`ifdef HT_HOST_PORT_STATS_EN
  // ---------------- statistics ----------------
  logic [31:0] st_search_q;
  logic [31:0] st_insert_q;
  logic [31:0] st_delete_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      st_search_q <= '0;
      st_insert_q <= '0;
      st_delete_q <= '0;
    end else if (res_fire) begin
      if (ht_res.opcode == OP_SEARCH && st_search_q != '1) st_search_q <= st_search_q + 32'd1;
      if (ht_res.opcode == OP_INSERT && st_insert_q != '1) st_insert_q <= st_insert_q + 32'd1;
      if (ht_res.opcode == OP_DELETE && st_delete_q != '1) st_delete_q <= st_delete_q + 32'd1;
    end
  end

  assign stat_search_o = st_search_q;
  assign stat_insert_o = st_insert_q;
  assign stat_delete_o = st_delete_q;
`endif

endmodule
